readout_packetizer: RTL and testbench



---
 rtl/readout_pkg.sv | 21 ++
 rtl/packet_buffer.sv | 21 ++
 rtl/readout_packetizer.sv | 149 ++++++++++++++
 tb/tb_readout_packetizer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// readout_pkg: shared state encoding, marker defaults and word field layout for the readout packetizer
package readout_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_HEADER, ST_PAYLOAD, ST_TRAILER} state_e;
  localparam logic [7:0] HEADER_ID_DEF  = 8'hA5;
  localparam logic [7:0] TRAILER_ID_DEF = 8'h5A;
  localparam int ID_MSB  = 31;
  localparam int ID_LSB  = 24;
  localparam int SEQ_MSB = 23;
  localparam int SEQ_LSB = 16;
  localparam int FLD_MSB = 15;
  localparam int FLD_LSB = 0;
  function automatic logic [31:0] make_word(input logic [7:0] id, input logic [7:0] seq,
                                            input logic [15:0] fld);
    logic [31:0] w;
    w = '0;
    w[ID_MSB:ID_LSB]   = id;
    w[SEQ_MSB:SEQ_LSB] = seq;
    w[FLD_MSB:FLD_LSB] = fld;
    return w;
  endfunction
endpackage

// File: rtl/packet_buffer.sv
// packet_buffer: simple dual-port payload RAM, one write port and one registered read port
module packet_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_q;
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end
  assign rd_data = rd_data_q;
endmodule

// File: rtl/readout_packetizer.sv
// readout_packetizer: drains a FIFO into a buffer and emits header/payload/trailer packets on a valid/ready stream
// Define PACKETIZER_CHECKSUM_EN to fill the trailer checksum field with the folded XOR of the payload.
module readout_packetizer import readout_pkg::*; #(
  parameter int         MAX_WORDS  = 256,
  parameter logic [7:0] HEADER_ID  = HEADER_ID_DEF,
  parameter logic [7:0] TRAILER_ID = TRAILER_ID_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [15:0] timeout_cycles,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic [15:0] pkt_count,
  output logic        busy
);
  localparam int AW = $clog2(MAX_WORDS);
  localparam int CW = AW + 1;
  state_e        state_q, state_d;
  logic [CW-1:0] wr_count_q, wr_count_d, emit_q, emit_d;
  logic          inflight_q, inflight_d;
  logic [15:0]   idle_q, idle_d, pkt_q, pkt_d, chk;
  logic [7:0]    seq_q, seq_d;
  logic [31:0]   tx_data_q, tx_data_d, buf_rd_data;
  logic          tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic          rd_cand, close, buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  packet_buffer #(.DEPTH(MAX_WORDS)) u_buf (
    .clk    (clk),
    .wr_en  (inflight_q),
    .wr_addr(wr_count_q[AW-1:0]),
    .wr_data(fifo_dout),
    .rd_en  (buf_rd_en),
    .rd_addr(buf_rd_addr),
    .rd_data(buf_rd_data)
  );
`ifdef PACKETIZER_CHECKSUM_EN
  logic [31:0] x_q, x_d;
  always_comb begin
    x_d = x_q;
    if (state_q == ST_TRAILER && tx_ready) x_d = '0;
    else if (inflight_q) x_d = x_q ^ fifo_dout;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) x_q <= '0;
    else x_q <= x_d;
  end
  assign chk = x_q[31:16] ^ x_q[15:0];
`else
  assign chk = 16'h0000;
`endif
  assign rd_cand = state_q == ST_FILL && !fifo_empty &&
                   (wr_count_q + CW'(inflight_q)) < CW'(MAX_WORDS);
  assign close = state_q == ST_FILL && !inflight_q && !rd_cand &&
                 (wr_count_q == CW'(MAX_WORDS) || (wr_count_q != '0 && idle_q >= timeout_cycles));
  assign fifo_rd_en = rd_cand && reset_n;
  assign inflight_d = fifo_rd_en;
  always_comb begin
    state_d     = state_q;
    wr_count_d  = wr_count_q + CW'(inflight_q);
    emit_d      = emit_q;
    idle_d      = idle_q;
    seq_d       = seq_q;
    pkt_d       = pkt_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    tx_last_d   = tx_last_q;
    buf_rd_en   = 1'b0;
    buf_rd_addr = AW'(emit_q + 1'b1);
    case (state_q)
      ST_IDLE: begin
        idle_d = '0;
        if (!fifo_empty) state_d = ST_FILL;
      end
      ST_FILL: begin
        idle_d = inflight_q ? 16'h0 : (&idle_q ? idle_q : idle_q + 16'h1);
        if (close) begin
          state_d     = ST_HEADER;
          tx_data_d   = make_word(HEADER_ID, seq_q, 16'(wr_count_q));
          tx_valid_d  = 1'b1;
          buf_rd_en   = 1'b1;
          buf_rd_addr = '0;
          emit_d      = '0;
        end
      end
      // the buffer output register holds the next payload word while the stream stalls
      ST_HEADER, ST_PAYLOAD: begin
        if (tx_ready) begin
          if (emit_q == wr_count_q) begin
            state_d   = ST_TRAILER;
            tx_data_d = make_word(TRAILER_ID, seq_q, chk);
            tx_last_d = 1'b1;
          end else begin
            state_d   = ST_PAYLOAD;
            tx_data_d = buf_rd_data;
            buf_rd_en = 1'b1;
            emit_d    = emit_q + 1'b1;
          end
        end
      end
      ST_TRAILER: begin
        if (tx_ready) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          seq_d      = seq_q + 8'h1;
          pkt_d      = pkt_q + 16'h1;
          wr_count_d = '0;
          emit_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_count_q <= '0;
      emit_q     <= '0;
      inflight_q <= 1'b0;
      idle_q     <= '0;
      seq_q      <= '0;
      pkt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      emit_q     <= emit_d;
      inflight_q <= inflight_d;
      idle_q     <= idle_d;
      seq_q      <= seq_d;
      pkt_q      <= pkt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
    end
  end
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_last   = tx_last_q;
  assign pkt_count = pkt_q;
  assign busy      = state_q != ST_IDLE;
endmodule

// File: tb/tb_readout_packetizer.sv
// tb_readout_packetizer: randomized scoreboard bench; packets predicted by chunking each FIFO burst into MAX_WORDS pieces
module tb_readout_packetizer;
  localparam int MW = 8;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [31:0] fifo_dout = '0;
  logic        fifo_empty, fifo_rd_en;
  logic [15:0] timeout_cycles = 16'd4;
  logic [31:0] tx_data;
  logic        tx_valid, tx_last;
  logic        tx_ready = 1;
  logic [15:0] pkt_count;
  logic        busy;
  readout_packetizer #(.MAX_WORDS(MW)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .timeout_cycles(timeout_cycles), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready), .pkt_count(pkt_count),
    .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, passes = 0, xfers = 0, rmode = 1;
  logic [31:0] fq[$];
  logic [31:0] burst_q[$];
  logic [32:0] expq[$];
  int fifo_n = 0;
  logic [7:0]  seq_m = 0;
  logic [15:0] pkts_m = 0;
  assign fifo_empty = fifo_n == 0;
  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction
  function automatic logic [15:0] cs(input logic [31:0] x);
`ifdef PACKETIZER_CHECKSUM_EN
    return x[31:16] ^ x[15:0];
`else
    return 16'h0000;
`endif
  endfunction
  // standard-read FIFO: data appears the cycle after the strobe
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_n > 0) begin
      fifo_dout <= fq.pop_front();
      fifo_n--;
    end
  end
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: tx_ready = $urandom_range(0, 3) != 0;
      2: tx_ready = !tx_ready;
      default: tx_ready = 1;
    endcase
  end
  logic        stall_prev = 0;
  logic [32:0] held;
  always @(negedge clk) begin
    if (reset_n) begin
      if (stall_prev) check("stall_hold", {tx_valid, tx_last, tx_data}, {1'b1, held});
      if (tx_valid && tx_ready) begin
        if (expq.size() == 0) check("unexpected_word", {tx_last, tx_data}, 64'h0);
        else check("stream_word", {tx_last, tx_data}, expq.pop_front());
        xfers++;
      end
      if (fifo_rd_en) check("rd_legal", {tx_valid, fifo_empty}, 64'h0);
      stall_prev = tx_valid && !tx_ready;
      held = {tx_last, tx_data};
    end else stall_prev = 0;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue_burst();
    int n = burst_q.size();
    for (int s = 0; s < n; s += MW) begin
      int len = (n - s < MW) ? n - s : MW;
      logic [31:0] x = '0;
      expq.push_back({1'b0, 8'hA5, seq_m, 16'(len)});
      for (int k = 0; k < len; k++) begin
        expq.push_back({1'b0, burst_q[s+k]});
        x ^= burst_q[s+k];
      end
      expq.push_back({1'b1, 8'h5A, seq_m, cs(x)});
      seq_m++;
      pkts_m++;
    end
    foreach (burst_q[i]) fq.push_back(burst_q[i]);
    fifo_n += n;
    burst_q.delete();
  endtask
  task automatic drain();
    int t = 0;
    while ((expq.size() != 0 || busy || fifo_n != 0) && t < 3000) begin
      step();
      t++;
    end
    check("drain_bound", t < 3000, 1);
  endtask
  task automatic rand_burst(input int lo, input int hi);
    int n = $urandom_range(lo, hi);
    for (int i = 0; i < n; i++) burst_q.push_back($urandom);
    issue_burst();
    drain();
  endtask
  initial begin
    repeat (3) step();
    @(negedge clk);
    check("reset_outputs", {tx_valid, tx_last, busy, fifo_rd_en, tx_data}, 64'h0);
    check("reset_pkt_count", pkt_count, 0);
    step();
    reset_n = 1;
    burst_q.push_back(32'h11111111);
    burst_q.push_back(32'h22222222);
    burst_q.push_back(32'h33333333);
    issue_burst();
    drain();
    check("pkt_count_one", pkt_count, 1);
    burst_q.push_back(32'h0001FFFE);
    issue_burst();
    drain();
    rand_burst(3 * MW, 3 * MW);
    for (int i = 0; i < 30; i++) begin
      timeout_cycles = 16'($urandom_range(0, 6));
      rmode = $urandom_range(0, 2);
      rand_burst(1, 20);
    end
    check("pkt_count_mid", pkt_count, pkts_m);
    rmode = 1;
    timeout_cycles = 16'd3;
    begin
      int base = xfers, t = 0;
      for (int i = 0; i < 6; i++) burst_q.push_back($urandom);
      issue_burst();
      while (xfers < base + 3 && t < 200) begin
        step();
        t++;
      end
      check("reach_payload", t < 200, 1);
    end
    reset_n = 0;
    step();
    reset_n = 1;
    expq.delete();
    fq.delete();
    fifo_n = 0;
    seq_m = 0;
    pkts_m = 0;
    @(negedge clk);
    check("post_reset", {tx_valid, tx_last, busy, tx_data}, 64'h0);
    check("post_reset_pkts", pkt_count, 0);
    step();
    for (int i = 0; i < 265; i++) begin
      timeout_cycles = 16'($urandom_range(0, 2));
      rmode = $urandom_range(0, 2);
      rand_burst(1, 3);
    end
    check("pkt_count_final", pkt_count, pkts_m);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
